// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
//  Shared definitions for the board I/O controller:
//   - register offsets of the memory-mapped window (word-aligned byte offsets)
//   - CPU clock-enable mode and seven-segment source enums
//   - reset value of the CTRL register
//   - 16-entry nibble -> active-low seven-segment code table (bit 0 = seg a)
// -----------------------------------------------------------------------------
package board_io_pkg;

   localparam logic [4:0] OFS_SW     = 5'h00;
   localparam logic [4:0] OFS_LED    = 5'h04;
   localparam logic [4:0] OFS_HEXVAL = 5'h08;
   localparam logic [4:0] OFS_CYCLE  = 5'h0C;
   localparam logic [4:0] OFS_CTRL   = 5'h10;

   typedef enum logic [1:0] {
      MODE_FULL = 2'd0,
      MODE_DIV  = 2'd1,
      MODE_STEP = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      SRC_HEXVAL = 2'd0,
      SRC_CYCLE  = 2'd1,
      SRC_DBG_A  = 2'd2,
      SRC_DBG_B  = 2'd3
   } hex_src_e;

   // Full speed, display the cycle counter.
   localparam logic [3:0] CTRL_RESET = 4'h4;

   // Ascending index range so the first entry below is the code for 0.
   localparam logic [0:15][6:0] SEG_LUT = {
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   // The reserved mode encoding behaves as full speed.
   function automatic mode_e decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_FULL : mode_e'(m);
   endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// -----------------------------------------------------------------------------
// hex7seg_lut
//  Converts one hexadecimal nibble into an active-low seven-segment pattern.
//  Ports:
//   nibble  in  4   value to display (0-F)
//   seg     out 7   segments g..a, active-low, seg[0] = segment a
// -----------------------------------------------------------------------------
module hex7seg_lut
   import board_io_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
//  Memory-mapped board I/O block sitting between the CPU data port and the
//  FPGA board. Generates the CPU clock enable (full speed / divided /
//  single-step), counts enabled, non-halted CPU cycles (saturating), holds an
//  LED register and drives NUM_HEX seven-segment digits from a selectable
//  32-bit source.
//
//  Register map (addr = word-aligned byte offset):
//   0x00 SW     RO  synchronised switches, zero-extended
//   0x04 LED    RW
//   0x08 HEXVAL RW
//   0x0C CYCLE  RO  any write clears it
//   0x10 CTRL   RW  [1:0] clock mode, [3:2] hex source
//
//  Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   io_sel    in   bus access targets this window
//   addr      in   5-bit offset
//   we        in   write strobe (committed only together with io_sel & cpu_ce)
//   wdata     in   write data
//   rdata     out  read data, combinational, zero when io_sel is low
//   sw        in   raw switches
//   step_btn  in   raw single-step button, active-low
//   halt      in   CPU end-of-program flag, freezes CYCLE
//   dbg_a/b   in   debug display sources
//   cpu_ce    out  registered CPU clock enable
//   led       out  LED register
//   hex       out  segments, active-low, digit 0 in [6:0]
//
//  Build option: define BOARD_IO_DEBOUNCE_EN to add a 2**16-sample stability
//  filter behind the synchronisers of sw and step_btn.
// -----------------------------------------------------------------------------
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NUM_SW  = 10,
   parameter int NUM_LED = 10,
   parameter int NUM_HEX = 6,
   parameter int DIV_W   = 26,
   parameter int CNT_W   = 32
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_sel,
   input  logic [4:0]           addr,
   input  logic                 we,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [NUM_SW-1:0]    sw,
   input  logic                 step_btn,
   input  logic                 halt,
   input  logic [31:0]          dbg_a,
   input  logic [31:0]          dbg_b,
   output logic                 cpu_ce,
   output logic [NUM_LED-1:0]   led,
   output logic [7*NUM_HEX-1:0] hex
);

   logic [NUM_SW-1:0]  sw_meta_reg, sw_sync_reg;
   logic               btn_meta_reg, btn_sync_reg, btn_prev_reg;
   logic [NUM_SW-1:0]  sw_clean;
   logic               btn_clean;
   logic [DIV_W-1:0]   presc_reg;
   logic               cpu_ce_reg, cpu_ce_next;
   logic [NUM_LED-1:0] led_reg;
   logic [31:0]        hexval_reg;
   logic [CNT_W-1:0]   cycle_reg, cycle_next;
   logic [3:0]         ctrl_reg;

   logic               wr_en;
   logic               tick;
   logic               step_fall;
   mode_e              mode;
   hex_src_e           hex_src;
   logic [31:0]        hex_src_val;
   logic               unused_src_bits;

   // ---------------------------------------------------------------------
   // Optional debounce stage behind the synchronisers
   // ---------------------------------------------------------------------
`ifdef BOARD_IO_DEBOUNCE_EN
   localparam int DB_W = 16;

   logic [NUM_SW-1:0] sw_cand_reg, sw_db_reg;
   logic [DB_W-1:0]   sw_cnt_reg;
   logic              btn_cand_reg, btn_db_reg;
   logic [DB_W-1:0]   btn_cnt_reg;

   // A candidate value is accepted only after it stayed unchanged for the
   // whole counter range; any change restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_cand_reg  <= '0;
         sw_db_reg    <= '0;
         sw_cnt_reg   <= '0;
         btn_cand_reg <= 1'b0;
         btn_db_reg   <= 1'b0;
         btn_cnt_reg  <= '0;
      end else begin
         if (sw_sync_reg != sw_cand_reg) begin
            sw_cand_reg <= sw_sync_reg;
            sw_cnt_reg  <= '0;
         end else if (&sw_cnt_reg) begin
            sw_db_reg <= sw_cand_reg;
         end else begin
            sw_cnt_reg <= sw_cnt_reg + DB_W'(1);
         end

         if (btn_sync_reg != btn_cand_reg) begin
            btn_cand_reg <= btn_sync_reg;
            btn_cnt_reg  <= '0;
         end else if (&btn_cnt_reg) begin
            btn_db_reg <= btn_cand_reg;
         end else begin
            btn_cnt_reg <= btn_cnt_reg + DB_W'(1);
         end
      end
   end

   assign sw_clean  = sw_db_reg;
   assign btn_clean = btn_db_reg;
`else
   assign sw_clean  = sw_sync_reg;
   assign btn_clean = btn_sync_reg;
`endif

   // ---------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------
   assign wr_en     = io_sel & we & cpu_ce_reg;
   assign mode      = decode_mode(ctrl_reg[1:0]);
   assign hex_src   = hex_src_e'(ctrl_reg[3:2]);
   assign tick      = &presc_reg;
   // Button is active-low: a press is a 1 -> 0 transition. The sync flops
   // reset to 0, so releasing reset with the button up is a rising edge
   // and cannot produce a step.
   assign step_fall = btn_prev_reg & ~btn_clean;

   always_comb begin
      cpu_ce_next = 1'b1;
      case (mode)
         MODE_DIV:  cpu_ce_next = tick;
         MODE_STEP: cpu_ce_next = step_fall;
         default:   cpu_ce_next = 1'b1;
      endcase
   end

   // A clear write beats a same-cycle increment.
   always_comb begin
      cycle_next = cycle_reg;
      if (wr_en && (addr == OFS_CYCLE)) begin
         cycle_next = '0;
      end else if (cpu_ce_reg && !halt && !(&cycle_reg)) begin
         cycle_next = cycle_reg + CNT_W'(1);
      end
   end

   always_comb begin
      rdata = '0;
      if (io_sel) begin
         case (addr)
            OFS_SW:     rdata = 32'(sw_clean);
            OFS_LED:    rdata = 32'(led_reg);
            OFS_HEXVAL: rdata = hexval_reg;
            OFS_CYCLE:  rdata = 32'(cycle_reg);
            OFS_CTRL:   rdata = 32'(ctrl_reg);
            default:    rdata = '0;
         endcase
      end
   end

   always_comb begin
      hex_src_val = hexval_reg;
      case (hex_src)
         SRC_HEXVAL: hex_src_val = hexval_reg;
         SRC_CYCLE:  hex_src_val = 32'(cycle_reg);
         SRC_DBG_A:  hex_src_val = dbg_a;
         default:    hex_src_val = dbg_b;
      endcase
   end

   // Nibbles above the last digit are not displayed.
   assign unused_src_bits = ^hex_src_val;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_meta_reg  <= '0;
         sw_sync_reg  <= '0;
         btn_meta_reg <= 1'b0;
         btn_sync_reg <= 1'b0;
         btn_prev_reg <= 1'b0;
         presc_reg    <= '0;
         cpu_ce_reg   <= 1'b0;
         led_reg      <= '0;
         hexval_reg   <= '0;
         cycle_reg    <= '0;
         ctrl_reg     <= CTRL_RESET;
      end else begin
         sw_meta_reg  <= sw;
         sw_sync_reg  <= sw_meta_reg;
         btn_meta_reg <= step_btn;
         btn_sync_reg <= btn_meta_reg;
         btn_prev_reg <= btn_clean;
         // Free-running: mode changes never restart the divider.
         presc_reg    <= presc_reg + DIV_W'(1);
         cpu_ce_reg   <= cpu_ce_next;
         cycle_reg    <= cycle_next;
         if (wr_en) begin
            case (addr)
               OFS_LED:    led_reg    <= wdata[NUM_LED-1:0];
               OFS_HEXVAL: hexval_reg <= wdata;
               OFS_CTRL:   ctrl_reg   <= wdata[3:0];
               default:    ;
            endcase
         end
      end
   end

   assign cpu_ce = cpu_ce_reg;
   assign led    = led_reg;

   // ---------------------------------------------------------------------
   // Seven-segment digits
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_digit
         hex7seg_lut u_lut (
            .nibble (hex_src_val[4*gi +: 4]),
            .seg    (hex[7*gi +: 7])
         );
      end
   endgenerate

endmodule
